// File: rtl/tetris_pkg.sv
// Shared board geometry and the line-clear sequencer state encoding.
package tetris_pkg;

    localparam int unsigned COLS = 10;
    localparam int unsigned ROWS = 20;
    localparam int unsigned XW   = 4;
    localparam int unsigned YW   = 5;

    localparam logic [XW-1:0] X_LAST  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(ROWS - 1);
    localparam logic [YW-1:0] CNT_MAX = YW'(ROWS);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StScanLast,
        StShift,
        StShiftLast,
        StZero,
        StDone
    } clr_state_e;

endpackage

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: owns the board ports while busy, scans rows bottom-up,
// removes each full row by copying everything above it down one row, then
// blanks row 0 and rescans the same row index.
module line_clear_ctrl
    import tetris_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [YW-1:0] lines_cleared,
    output logic [XW-1:0] board_rx,
    output logic [YW-1:0] board_ry,
    input  logic          board_rdata,
    output logic          board_we,
    output logic [XW-1:0] board_wx,
    output logic [YW-1:0] board_wy,
    output logic          board_wdata
);

    clr_state_e    state_q, state_d;
    logic [YW-1:0] row_q, row_d;
    logic [YW-1:0] src_q, src_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [YW-1:0] lines_q, lines_d;
    // Write address trails the copy read by one cycle to line up with rdata.
    logic [XW-1:0] wx_q;
    logic [YW-1:0] wy_q;
    logic          row_full;

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            src_q   <= '0;
            x_q     <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            lines_q <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            src_q   <= src_d;
            x_q     <= x_d;
            count_q <= count_d;
            full_q  <= full_d;
            lines_q <= lines_d;
            wx_q    <= x_q;
            wy_q    <= src_q + YW'(1);
        end
    end

    // Next-state logic and board port drive.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        src_d       = src_q;
        x_d         = x_q;
        count_d     = count_q;
        full_d      = full_q;
        lines_d     = lines_q;
        row_full    = 1'b0;
        board_rx    = '0;
        board_ry    = '0;
        board_we    = 1'b0;
        board_wx    = '0;
        board_wy    = '0;
        board_wdata = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    row_d   = Y_LAST;
                    x_d     = '0;
                    count_d = '0;
                    full_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                board_rx = x_q;
                board_ry = row_q;
                x_d      = x_q + XW'(1);
                // rdata belongs to the previous cycle's read; none yet at x=0.
                if (x_q != '0) begin
                    full_d = full_q & board_rdata;
                end
                if (x_q == X_LAST) begin
                    state_d = StScanLast;
                end
            end
            StScanLast: begin
                row_full = full_q & board_rdata;
                x_d      = '0;
                if (row_full) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + YW'(1);
                    end
                    if (row_q == '0) begin
                        state_d = StZero;
                    end else begin
                        src_d   = row_q - YW'(1);
                        state_d = StShift;
                    end
                end else if (row_q == '0) begin
                    lines_d = count_q;
                    state_d = StDone;
                end else begin
                    row_d   = row_q - YW'(1);
                    full_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StShift: begin
                board_rx = x_q;
                board_ry = src_q;
                x_d      = x_q + XW'(1);
                if (x_q != '0) begin
                    board_we    = 1'b1;
                    board_wx    = wx_q;
                    board_wy    = wy_q;
                    board_wdata = board_rdata;
                end
                if (x_q == X_LAST) begin
                    state_d = StShiftLast;
                end
            end
            StShiftLast: begin
                board_we    = 1'b1;
                board_wx    = wx_q;
                board_wy    = wy_q;
                board_wdata = board_rdata;
                x_d         = '0;
                if (src_q == '0) begin
                    state_d = StZero;
                end else begin
                    src_d   = src_q - YW'(1);
                    state_d = StShift;
                end
            end
            StZero: begin
                board_we = 1'b1;
                board_wx = x_q;
                board_wy = '0;
                x_d      = x_q + XW'(1);
                if (x_q == X_LAST) begin
                    // Row index unchanged: the row shifted into it gets rescanned.
                    x_d     = '0;
                    full_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board memory model plus a row-compaction reference.
module tb_line_clear_ctrl;
    import tetris_pkg::*;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [YW-1:0] lines_cleared;
    logic [XW-1:0] board_rx;
    logic [YW-1:0] board_ry;
    logic          board_rdata = 1'b0;
    logic          board_we;
    logic [XW-1:0] board_wx;
    logic [YW-1:0] board_wy;
    logic          board_wdata;

    logic [COLS-1:0] mem       [ROWS];
    logic [COLS-1:0] init_rows [ROWS];
    logic [COLS-1:0] exp_rows  [ROWS];
    logic            load_req;
    int              exp_cnt, exp_lat, exp_wr;
    int              wr_cnt = 0, done_cnt = 0, oob_wr = 0;
    int              n_total = 0, n_bad = 0;

    line_clear_ctrl dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .board_rx      (board_rx),
        .board_ry      (board_ry),
        .board_rdata   (board_rdata),
        .board_we      (board_we),
        .board_wx      (board_wx),
        .board_wy      (board_wy),
        .board_wdata   (board_wdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Simple dual-port board: registered read, write visible from the next cycle.
    always @(posedge CLOCK_50) begin
        if (load_req) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= init_rows[r];
        end else if (board_we) begin
            if (int'(board_wx) < COLS && int'(board_wy) < ROWS)
                mem[int'(board_wy)][int'(board_wx)] <= board_wdata;
            else
                oob_wr <= oob_wr + 1;
        end
        if (int'(board_rx) < COLS && int'(board_ry) < ROWS)
            board_rdata <= mem[int'(board_ry)][int'(board_rx)];
        else
            board_rdata <= 1'b0;
        if (board_we) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full rows vanish and the remaining rows keep their order, packed at the bottom.
    // The k-th removed row (from the bottom) sits at r+k when removed; each removal
    // costs a rescan, a copy of every row above it and a blanking pass.
    task automatic compute_model();
        logic [COLS-1:0] kept[$];
        int k;
        k       = 0;
        exp_lat = 221;
        exp_wr  = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (init_rows[r] == {COLS{1'b1}}) begin
                exp_lat += 11 + 11 * (r + k) + 10;
                exp_wr  += 10 * (r + k) + 10;
                k++;
            end else begin
                kept.push_back(init_rows[r]);
            end
        end
        exp_cnt = k;
        for (int r = ROWS - 1; r >= 0; r--) begin
            int idx;
            idx = ROWS - 1 - r;
            exp_rows[r] = (idx < kept.size()) ? kept[idx] : '0;
        end
    endtask

    task automatic load_board();
        load_req = 1'b1;
        @(posedge CLOCK_50); #1;
        load_req = 1'b0;
    endtask

    task automatic clear_init();
        for (int r = 0; r < ROWS; r++) init_rows[r] = '0;
    endtask

    task automatic run_board(input string name, input int extra_at);
        int cyc, wr0, dn0, oob0;
        compute_model();
        load_board();
        wr0  = wr_cnt;
        dn0  = done_cnt;
        oob0 = oob_wr;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        cyc   = 1;
        start = 1'b0;
        while (!done && cyc < 20000) begin
            start = (cyc == extra_at);
            @(posedge CLOCK_50); #1;
            cyc++;
        end
        start = 1'b0;
        check_eq({name, "_done_seen"}, int'(done), 1);
        check_eq({name, "_latency"}, cyc, exp_lat);
        check_eq({name, "_lines"}, int'(lines_cleared), exp_cnt);
        check_eq({name, "_busy_at_done"}, int'(busy), 1);
        @(posedge CLOCK_50); #1;
        check_eq({name, "_done_pulse"}, int'(done), 0);
        check_eq({name, "_idle_after"}, int'(busy), 0);
        check_eq({name, "_lines_held"}, int'(lines_cleared), exp_cnt);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq({name, "_done_count"}, done_cnt - dn0, 1);
        check_eq({name, "_writes"}, wr_cnt - wr0, exp_wr);
        check_eq({name, "_oob_writes"}, oob_wr - oob0, 0);
        for (int r = 0; r < ROWS; r++)
            check_eq($sformatf("%s_row%0d", name, r), int'(mem[r]), int'(exp_rows[r]));
    endtask

    initial begin
        int n;
        logic [COLS-1:0] v;
        reset    = 1'b1;
        start    = 1'b0;
        load_req = 1'b0;
        clear_init();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_we", int'(board_we), 0);
        check_eq("rst_lines", int'(lines_cleared), 0);
        check_eq("rst_addr", int'({board_rx, board_ry, board_wx, board_wy, board_wdata}), 0);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;

        clear_init();
        run_board("empty", 0);

        clear_init();
        init_rows[19] = '1;
        init_rows[18] = 10'b00_0000_1000;
        run_board("row19", 0);

        clear_init();
        for (int r = 16; r < 20; r++) init_rows[r] = '1;
        run_board("four", 0);

        clear_init();
        init_rows[19] = '1;
        init_rows[17] = '1;
        init_rows[18] = 10'b00_0000_0001;
        run_board("split", 0);

        clear_init();
        init_rows[19] = '1;
        init_rows[18] = 10'b00_0000_1000;
        run_board("restart", 50);

        // Abort in the middle of a copy pass.
        clear_init();
        init_rows[19] = '1;
        init_rows[10] = 10'b10_1010_1010;
        load_board();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        n = 0;
        while (!board_we && n < 1000) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        check_eq("abort_we_seen", int'(board_we), 1);
        repeat (5) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_we", int'(board_we), 0);
        reset = 1'b0;
        run_board("after_abort", 0);

        for (int r = 0; r < ROWS; r++) init_rows[r] = '1;
        run_board("all_full", 0);

        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(2, 0) == 0) begin
                    init_rows[r] = '1;
                end else begin
                    v = COLS'($urandom);
                    v[$urandom_range(COLS - 1, 0)] = 1'b0;
                    init_rows[r] = v;
                end
            end
            run_board($sformatf("rand%0d", t), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
